shift_reg_p_sync: RTL and testbench
===================================

SHIFT_REG_P_SYNC -- requirements
Module: shift_reg_p_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width; legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 4, burst-length width; the value must satisfy 2**CNT_W > WIDTH.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Set  in  1  synchronous, active-high preset (all ones).
REQ-006 SHALL have port mode  in  3  operation: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 11x hold.
REQ-007 SHALL have port d  in  WIDTH  parallel load data.
REQ-008 SHALL have port sin  in  1  serial input: into LSB for shl, into MSB for shr.
REQ-009 SHALL have port start  in  1  burst request, sampled only in IDLE.
REQ-010 SHALL have port len  in  CNT_W  burst shift count, sampled with start.
REQ-011 SHALL have port q  out  WIDTH  register contents.
REQ-012 SHALL have port n_q  out  WIDTH  bitwise complement of q, combinational.
REQ-013 SHALL have port sout  out  1  registered copy of the last bit shifted or rotated out.
REQ-014 SHALL have port busy  out  1  high while in SHIFT.
REQ-015 SHALL have port done  out  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL resolve per-edge priority in this order: Reset, then Set, then burst, then mode.
REQ-017 SHALL, in IDLE with start=0, apply mode once per edge, with q updated at the same edge.
REQ-018 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-019 SHALL, on IDLE with start=1 and len>0 and mode in shl/shr/rotl/rotr: latch the operation and len, leave q unchanged at that edge, and go to SHIFT.
REQ-020 SHALL, in SHIFT, perform exactly one latched operation per edge and decrement the count; after the edge performing the final operation it goes to DONE.
REQ-021 SHALL, for a start sampled at edge k, shift at edges k+1..k+len, with busy high from k to k+len and done high from k+len to k+len+1.
REQ-022 SHALL, for start with len=0 or a non-shift mode, go directly to DONE with q unchanged and busy never high.
REQ-023 SHALL, in DONE, hold q, ignore start and mode, assert done, and return to IDLE next edge.
REQ-024 SHALL ignore mode and start while in SHIFT.
REQ-025 SHALL update sout only on shift/rotate edges: MSB-out for shl/rotl, LSB-out for shr/rotr; otherwise hold.
REQ-026 SHALL make rotates lossless, ignoring sin.

Reset
REQ-027 SHALL, on Reset=1 at any edge, including mid-burst: q=0, sout=0, state IDLE, busy=0, done=0, count=0.
REQ-028 SHALL, on Set=1 with Reset=0, including mid-burst: q all ones, sout=0, state IDLE, aborting any burst with no done pulse.

Configuration
REQ-029 SHALL, with SHREG_PARITY_EN defined, add output port parity (1 bit) equal to the XOR of all q bits, combinational.
REQ-030 SHALL, without SHREG_PARITY_EN, have no parity port and no parity logic.

Structure
REQ-031 SHALL take mode encodings (MODE_HOLD..MODE_ROTR) and the FSM state encoding from package shift_reg_pkg.
REQ-032 SHALL isolate the FSM plus length counter in sub-module shift_reg_ctrl; the datapath stays in shift_reg_p_sync.

Verification (WIDTH=8, CNT_W=4)
REQ-033 SHALL verify: Reset=1 and Set=1 held together for one edge -> q=0x00, n_q=0xFF, busy=0, done=0.
REQ-034 SHALL verify: mode=load, d=0xA5 -> q=0xA5; then mode=shl, sin=1 -> q=0x4B, sout=1.
REQ-035 SHALL verify: q=0x81, mode=rotr, start=1, len=3 -> busy high 3 cycles, then q=0x30 and done high exactly 1 cycle.
REQ-036 SHALL verify: start=1, len=0 -> done pulses on the next edge, q unchanged, busy stays 0.
REQ-037 SHALL verify: q=0x00, shl burst len=5, Set=1 after the 2nd shift -> q=0xFF, busy=0, no done pulse.
REQ-038 SHALL verify: with SHREG_PARITY_EN, load 0x07 -> parity=1; load 0x03 -> parity=0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared mode encodings, FSM states and helpers for the shift_reg_p_sync block.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_reg_ctrl.sv
// Burst controller: IDLE/SHIFT/DONE FSM with length counter; selects the
// operation the datapath applies on each edge.
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Set,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] len,
  output logic [2:0]       op,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (Set) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_shift_mode(mode) && (len != '0)) begin
              state_q <= ST_SHIFT;
              cnt_q   <= len;
              op_q    <= mode;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running mode only acts in IDLE without a start request; SHIFT replays the latched op.
  always_comb begin
    op = MODE_HOLD;
    if (state_q == ST_IDLE && !start) op = mode;
    else if (state_q == ST_SHIFT)     op = op_q;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/shift_reg_p_sync.sv
// Universal shift register with burst controller and sync reset/preset.
// Optional parity output enabled by defining SHREG_PARITY_EN.
module shift_reg_p_sync
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Set,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] n_q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [2:0]       op;

  shift_reg_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk   (clk),
    .Reset (Reset),
    .Set   (Set),
    .start (start),
    .mode  (mode),
    .len   (len),
    .op    (op),
    .busy  (busy),
    .done  (done)
  );

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    case (op)
      MODE_LOAD: q_d = d;
      MODE_SHL: begin
        q_d    = {q_q[WIDTH-2:0], sin};
        sout_d = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_d    = {sin, q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      MODE_ROTL: begin
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_d = q_q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_d    = {q_q[0], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      q_q    <= '0;
      sout_q <= 1'b0;
    end else if (Set) begin
      q_q    <= '1;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  assign q    = q_q;
  assign n_q  = ~q_q;
  assign sout = sout_q;

`ifdef SHREG_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_shift_reg_p_sync.sv
// Directed self-checking bench for shift_reg_p_sync (WIDTH=8, CNT_W=4).
module tb_shift_reg_p_sync;

  logic       clk = 1'b0;
  logic       Reset, Set, sin, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] len;
  logic [7:0] q, n_q;
  logic       sout, busy, done;
`ifdef SHREG_PARITY_EN
  logic       parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_reg_p_sync #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .Set   (Set),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .start (start),
    .len   (len),
    .q     (q),
    .n_q   (n_q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
`ifdef SHREG_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, "_q"}, 64'(q), 64'(eq));
    check({tag, "_busy"}, 64'(busy), 64'(eb));
    check({tag, "_done"}, 64'(done), 64'(ed));
  endtask

  initial begin
    Reset = 1'b1; Set = 1'b1; mode = 3'b000; d = 8'h00; sin = 1'b0; start = 1'b0; len = 4'd0;
    tick();
    check_state("rst_set", 8'h00, 1'b0, 1'b0);
    check("rst_nq", 64'(n_q), 64'hFF);
    check("rst_sout", 64'(sout), 64'h0);
    Reset = 1'b0; Set = 1'b0;

    // load then single shift-left with sin=1
    mode = 3'b001; d = 8'hA5;
    tick();
    check("load_a5", 64'(q), 64'hA5);
    mode = 3'b010; sin = 1'b1;
    tick();
    check("shl_q", 64'(q), 64'h4B);
    check("shl_sout", 64'(sout), 64'h1);

    // rotr burst of 3 on 0x81; mode changes during SHIFT must be ignored
    mode = 3'b001; d = 8'h81;
    tick();
    mode = 3'b101; start = 1'b1; len = 4'd3;
    tick();
    check_state("rotr_k", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b001; d = 8'hFF;
    tick();
    check_state("rotr_1", 8'hC0, 1'b1, 1'b0);
    check("rotr_1_sout", 64'(sout), 64'h1);
    tick();
    check_state("rotr_2", 8'h60, 1'b1, 1'b0);
    check("rotr_2_sout", 64'(sout), 64'h0);
    // in DONE start and mode are ignored
    start = 1'b1; mode = 3'b010; len = 4'd2;
    tick();
    check_state("rotr_3", 8'h30, 1'b0, 1'b1);
    tick();
    check_state("rotr_after", 8'h30, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;

    // len=0 burst goes straight to DONE
    mode = 3'b010; start = 1'b1; len = 4'd0;
    tick();
    check_state("len0", 8'h30, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick();
    check_state("len0_after", 8'h30, 1'b0, 1'b0);

    // start with non-shift mode behaves like len=0
    mode = 3'b001; d = 8'h55; start = 1'b1; len = 4'd3;
    tick();
    check_state("nonshift", 8'h30, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick();
    check_state("nonshift_after", 8'h30, 1'b0, 1'b0);

    // Set aborts a shl burst after the 2nd shift
    Reset = 1'b1;
    tick();
    check("rst2_q", 64'(q), 64'h00);
    Reset = 1'b0; mode = 3'b010; sin = 1'b1; start = 1'b1; len = 4'd5;
    tick();
    check_state("abort_k", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    tick();
    check_state("abort_2", 8'h03, 1'b1, 1'b0);
    Set = 1'b1;
    tick();
    check_state("abort_set", 8'hFF, 1'b0, 1'b0);
    check("abort_sout", 64'(sout), 64'h0);
    Set = 1'b0; mode = 3'b000;
    tick();
    check_state("abort_after", 8'hFF, 1'b0, 1'b0);
    tick();
    check_state("abort_after2", 8'hFF, 1'b0, 1'b0);

    // Reset mid-burst on shr
    mode = 3'b011; sin = 1'b0; start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    tick();
    check_state("shr_1", 8'h7F, 1'b1, 1'b0);
    check("shr_1_sout", 64'(sout), 64'h1);
    Reset = 1'b1;
    tick();
    check_state("shr_rst", 8'h00, 1'b0, 1'b0);
    check("shr_rst_sout", 64'(sout), 64'h0);
    Reset = 1'b0; mode = 3'b000;
    tick();
    check_state("shr_rst_after", 8'h00, 1'b0, 1'b0);

    // single rotl, reserved mode holds, shr with sin=1
    mode = 3'b001; d = 8'h81;
    tick();
    mode = 3'b100; sin = 1'b0;
    tick();
    check("rotl_q", 64'(q), 64'h03);
    check("rotl_sout", 64'(sout), 64'h1);
    mode = 3'b111;
    tick();
    check("hold7_q", 64'(q), 64'h03);
    check("hold7_sout", 64'(sout), 64'h1);
    mode = 3'b011; sin = 1'b1;
    tick();
    check("shr_sin_q", 64'(q), 64'h81);
    check("shr_sin_nq", 64'(n_q), 64'h7E);

`ifdef SHREG_PARITY_EN
    mode = 3'b001; d = 8'h07;
    tick();
    check("parity_07", 64'(parity), 64'h1);
    d = 8'h03;
    tick();
    check("parity_03", 64'(parity), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
